// File: rtl/if_id_register_if.sv
// IF/ID pipeline register bus.
// The fetch side (IF stage, instruction memory, hazard and branch units)
// uses the master modport. The pipeline register uses the slave modport.
// With IF_ID_PERF_EN defined, the bus also carries the bubble counter.
interface if_id_register_if;
    logic        IFIDWrite;
    logic        Flush;
    logic [31:0] IF_PC;
    logic [31:0] IF_instruction;
    logic [31:0] ID_PC;
    logic [31:0] ID_instruction;
    logic        ID_valid;
`ifdef IF_ID_PERF_EN
    logic [31:0] bubble_cnt;

    modport master (
        output IFIDWrite,
        output Flush,
        output IF_PC,
        output IF_instruction,
        input  ID_PC,
        input  ID_instruction,
        input  ID_valid,
        input  bubble_cnt
    );

    modport slave (
        input  IFIDWrite,
        input  Flush,
        input  IF_PC,
        input  IF_instruction,
        output ID_PC,
        output ID_instruction,
        output ID_valid,
        output bubble_cnt
    );
`else
    modport master (
        output IFIDWrite,
        output Flush,
        output IF_PC,
        output IF_instruction,
        input  ID_PC,
        input  ID_instruction,
        input  ID_valid
    );

    modport slave (
        input  IFIDWrite,
        input  Flush,
        input  IF_PC,
        input  IF_instruction,
        output ID_PC,
        output ID_instruction,
        output ID_valid
    );
`endif
endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register.
// The synchronous instruction memory returns data one cycle after its
// address. This register therefore remembers the PC it fetched (pc_d) and
// pairs it with the data that comes back. It presents a valid-tagged
// {PC, instruction} to decode. It also handles hazard stalls (hold
// everything) and branch flushes (kill both the returning and the
// addressed instruction, which gives two bubbles).
// Optional feature macro: IF_ID_PERF_EN adds a saturating 32-bit
// bubble_cnt output.
module if_id_register #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input logic           clk,
    input logic           rst,
    if_id_register_if.slave bus
);

    // pc_d: the PC whose memory data appears on IF_instruction this cycle.
    // fetch_v: that data is on the correct path and is worth issuing.
    logic [31:0] pc_d;
    logic        fetch_v;

    logic [31:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;

    // High when this edge places a bubble into ID.
    // A flush wins over a stall, so Flush alone forces a bubble.
    logic        load_bubble;

    // Decide whether the coming edge loads a bubble into decode
    always_comb begin
        load_bubble = bus.Flush || (bus.IFIDWrite && !fetch_v);
    end

    // Track which PC the memory is returning and whether it is live
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_d    <= 32'd0;
            fetch_v <= 1'b0;
        end else if (bus.Flush) begin
            // The addressed PC is on the wrong path; its data dies next edge
            pc_d    <= bus.IF_PC;
            fetch_v <= 1'b0;
        end else if (bus.IFIDWrite) begin
            pc_d    <= bus.IF_PC;
            fetch_v <= 1'b1;
        end
    end

    // Load the decode-facing register: a bubble, a real instruction, or hold
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_pc          <= 32'd0;
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
        end else if (load_bubble) begin
            // Every bubble looks the same: PC 0, canonical NOP, not valid
            id_pc          <= 32'd0;
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
        end else if (bus.IFIDWrite) begin
            id_pc          <= pc_d;
            id_instruction <= bus.IF_instruction;
            id_valid       <= 1'b1;
        end
    end

    assign bus.ID_PC          = id_pc;
    assign bus.ID_instruction = id_instruction;
    assign bus.ID_valid       = id_valid;

`ifdef IF_ID_PERF_EN
    logic [31:0] bubble_cnt_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Count edges that load a bubble into ID; held edges are not counted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bubble_cnt_q <= 32'd0;
        end else if (load_bubble) begin
            bubble_cnt_q <= sat_inc(bubble_cnt_q);
        end
    end

    assign bus.bubble_cnt = bubble_cnt_q;
`endif

endmodule
